hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS core; companion to the EX-stage forwarding logic.

---
 rtl/hazard_stall_ctrl_pkg.sv | 29 ++
 rtl/hazard_stall_ctrl_load_use_detect.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM states,
// register-field width and the bundle of per-cycle pipeline control bits.
package hazard_stall_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_MISS = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic pipe_stall;
  } ctrl_t;

  // Free-running pipe: PC and IF/ID advance, nothing squashed or held.
  localparam ctrl_t CTRL_RUN = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    idex_bubble: 1'b0,
    ifid_flush:  1'b0,
    pipe_stall:  1'b0
  };

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use comparator: flags when a load in EX writes a register that the
// instruction in ID reads. Register $0 never creates a dependency.
module hazard_stall_ctrl_load_use_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             lu_hazard
);

  logic [REG_W-1:0] src [2];
  logic [1:0]       src_match;

  assign src[0] = id_rs;
  assign src[1] = id_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_match[gi] = (ex_rt == src[gi]);
  end

  assign lu_hazard = ex_mem_read && (ex_rt != '0) && (|src_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: D-cache freeze, load-use bubble, IF/ID flush
// and sticky miss timeout. Define HAZARD_PERF_CNT_EN to build the perf counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = 255,
  parameter int TO_W         = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ID_RS_i,
  input  logic [REG_W-1:0] ID_RT_i,
  input  logic             EX_MemRead_i,
  input  logic [REG_W-1:0] EX_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             Dcache_stall_i,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IDEX_Bubble_o,
  output logic             IFID_Flush_o,
  output logic             Pipe_Stall_o,
  output logic             Timeout_o,
  output logic [CNT_W-1:0] Lu_cnt_o,
  output logic [CNT_W-1:0] Miss_cnt_o,
  output logic [CNT_W-1:0] Flush_cnt_o
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MISS_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  logic            lu_hazard;
  ctrl_t           ctrl;
  state_e          state_reg, state_next;
  logic [TO_W-1:0] miss_dur_reg, miss_dur_next;
  logic            timeout_reg, timeout_next;

  hazard_stall_ctrl_load_use_detect u_lu_detect (
    .ex_mem_read (EX_MemRead_i),
    .ex_rt       (EX_Rt_i),
    .id_rs       (ID_RS_i),
    .id_rt       (ID_RT_i),
    .lu_hazard   (lu_hazard)
  );

  // Same-cycle control; a miss outranks load-use, which outranks the flush
  // (the branch re-resolves once the bubble has gone down the pipe).
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst_i) begin
      ctrl = CTRL_RUN;
    end else if (Dcache_stall_i) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.pipe_stall = 1'b1;
    end else if (lu_hazard) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_bubble = 1'b1;
    end else if (Branch_taken_i) begin
      ctrl.ifid_flush = 1'b1;
    end
  end

  assign PC_Write_o    = ctrl.pc_write;
  assign IFID_Write_o  = ctrl.ifid_write;
  assign IDEX_Bubble_o = ctrl.idex_bubble;
  assign IFID_Flush_o  = ctrl.ifid_flush;
  assign Pipe_Stall_o  = ctrl.pipe_stall;

  // Exit from S_MISS needs no special case: the first cycle with the stall
  // dropped already runs the normal priority chain above.
  always_comb begin
    state_next    = Dcache_stall_i ? S_MISS : S_RUN;
    miss_dur_next = '0;
    if (Dcache_stall_i) begin
      if (state_reg == S_RUN) begin
        miss_dur_next = TO_ONE;
      end else if (miss_dur_reg != TO_LIMIT) begin
        miss_dur_next = miss_dur_reg + TO_ONE;
      end else begin
        miss_dur_next = miss_dur_reg;
      end
    end
    timeout_next = timeout_reg | (miss_dur_next == TO_LIMIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= S_RUN;
      miss_dur_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      miss_dur_reg <= miss_dur_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign Timeout_o = timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] lu_cnt_reg, miss_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_cnt_reg    <= '0;
      miss_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (ctrl.idex_bubble) lu_cnt_reg    <= lu_cnt_reg + CNT_ONE;
      if (ctrl.pipe_stall)  miss_cnt_reg  <= miss_cnt_reg + CNT_ONE;
      if (ctrl.ifid_flush)  flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign Lu_cnt_o    = lu_cnt_reg;
  assign Miss_cnt_o  = miss_cnt_reg;
  assign Flush_cnt_o = flush_cnt_reg;
`else
  assign Lu_cnt_o    = '0;
  assign Miss_cnt_o  = '0;
  assign Flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model of the sequencing rules.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        ex_mr = 1'b0, br = 1'b0, st = 1'b0;

  logic        pcw, ifw, bub, fl, pst, to;
  logic [15:0] lu_cnt, miss_cnt, flush_cnt;
  logic        pcw3, ifw3, bub3, fl3, pst3, to3;
  logic [15:0] lu_cnt3, miss_cnt3, flush_cnt3;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .ID_RS_i(id_rs), .ID_RT_i(id_rt),
    .EX_MemRead_i(ex_mr), .EX_Rt_i(ex_rt), .Branch_taken_i(br), .Dcache_stall_i(st),
    .PC_Write_o(pcw), .IFID_Write_o(ifw), .IDEX_Bubble_o(bub), .IFID_Flush_o(fl),
    .Pipe_Stall_o(pst), .Timeout_o(to), .Lu_cnt_o(lu_cnt), .Miss_cnt_o(miss_cnt),
    .Flush_cnt_o(flush_cnt)
  );

  hazard_stall_ctrl #(.MISS_TIMEOUT(3), .TO_W(2), .CNT_W(16)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .ID_RS_i(id_rs), .ID_RT_i(id_rt),
    .EX_MemRead_i(ex_mr), .EX_Rt_i(ex_rt), .Branch_taken_i(br), .Dcache_stall_i(st),
    .PC_Write_o(pcw3), .IFID_Write_o(ifw3), .IDEX_Bubble_o(bub3), .IFID_Flush_o(fl3),
    .Pipe_Stall_o(pst3), .Timeout_o(to3), .Lu_cnt_o(lu_cnt3), .Miss_cnt_o(miss_cnt3),
    .Flush_cnt_o(flush_cnt3)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_lu = '0, m_miss = '0, m_flush = '0;
  int          m_run = 0;
  bit          m_to = 1'b0, m_to3 = 1'b0;

  function automatic bit lu_rule();
    return ex_mr && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  // {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Pipe_Stall}
  function automatic logic [4:0] exp_ctrl();
    if (rst_i) return 5'b11000;
    if (st) return 5'b00001;
    if (lu_rule()) return 5'b00100;
    if (br) return 5'b11010;
    return 5'b11000;
  endfunction

  function automatic logic [15:0] cnt_exp(input logic [15:0] v);
    return PERF_EN ? v : 16'd0;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_lu <= '0; m_miss <= '0; m_flush <= '0; m_run <= 0; m_to <= 1'b0; m_to3 <= 1'b0;
    end else if (st) begin
      m_miss <= m_miss + 16'd1;
      m_run  <= m_run + 1;
      if (m_run + 1 >= 255) m_to <= 1'b1;
      if (m_run + 1 >= 3) m_to3 <= 1'b1;
    end else begin
      m_run <= 0;
      if (lu_rule()) m_lu <= m_lu + 16'd1;
      else if (br) m_flush <= m_flush + 16'd1;
    end
  end

  // Drive one cycle's inputs at the falling edge, settle, then let the caller sample.
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] ert, input logic b, input logic s);
    @(negedge clk_i);
    id_rs = rs; id_rt = rt; ex_mr = mr; ex_rt = ert; br = b; st = s;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_i = 1'b1;
    id_rs = 5'd2; ex_rt = 5'd2; ex_mr = 1'b1; br = 1'b1; st = 1'b1;
    #2;
    n_total++; if ({pcw, ifw, bub, fl, pst} !== 5'b11000) $display("FAIL reset_ctrl got %b exp %b", {pcw, ifw, bub, fl, pst}, 5'b11000); else n_pass++;
    n_total++; if (to !== 1'b0 || to3 !== 1'b0) $display("FAIL reset_timeout got %b/%b exp 0/0", to, to3); else n_pass++;
    n_total++; if ({lu_cnt, miss_cnt, flush_cnt} !== 48'd0) $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", lu_cnt, miss_cnt, flush_cnt); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0; id_rs = '0; ex_rt = '0; ex_mr = 1'b0; br = 1'b0; st = 1'b0;
  endtask

  task automatic test_load_use();
    logic [15:0] lu_before;
    set_in(5'd2, 5'd5, 1'b1, 5'd2, 1'b0, 1'b0);
    lu_before = m_lu;
    n_total++; if ({pcw, ifw, bub, fl, pst} !== 5'b00100) $display("FAIL lu_ctrl got %b exp %b", {pcw, ifw, bub, fl, pst}, 5'b00100); else n_pass++;
    set_in(5'd2, 5'd5, 1'b0, 5'd2, 1'b0, 1'b0);
    n_total++; if (pcw !== 1'b1 || bub !== 1'b0) $display("FAIL lu_release got pcw=%b bub=%b exp pcw=1 bub=0", pcw, bub); else n_pass++;
    n_total++; if (lu_cnt !== cnt_exp(lu_before + 16'd1)) $display("FAIL lu_cnt got %0d exp %0d", lu_cnt, cnt_exp(lu_before + 16'd1)); else n_pass++;
  endtask

  task automatic test_zero_reg();
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    n_total++; if (pcw !== 1'b1 || bub !== 1'b0 || ifw !== 1'b1) $display("FAIL zero_reg got pcw=%b ifw=%b bub=%b exp 1/1/0", pcw, ifw, bub); else n_pass++;
  endtask

  task automatic test_miss();
    logic [15:0] miss_before;
    miss_before = m_miss;
    for (int i = 0; i < 4; i++) begin
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
      n_total++; if ({pcw, ifw, bub, fl, pst} !== 5'b00001) $display("FAIL miss_ctrl[%0d] got %b exp %b", i, {pcw, ifw, bub, fl, pst}, 5'b00001); else n_pass++;
    end
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (pst !== 1'b0 || pcw !== 1'b1) $display("FAIL miss_exit got pst=%b pcw=%b exp 0/1", pst, pcw); else n_pass++;
    n_total++; if (miss_cnt !== cnt_exp(miss_before + 16'd4)) $display("FAIL miss_cnt got %0d exp %0d", miss_cnt, cnt_exp(miss_before + 16'd4)); else n_pass++;
  endtask

  task automatic test_lu_branch();
    logic [15:0] flush_before;
    set_in(5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    flush_before = m_flush;
    n_total++; if ({pcw, ifw, bub, fl, pst} !== 5'b00100) $display("FAIL lubr_bubble got %b exp %b", {pcw, ifw, bub, fl, pst}, 5'b00100); else n_pass++;
    set_in(5'd3, 5'd4, 1'b0, 5'd3, 1'b1, 1'b0);
    n_total++; if ({pcw, ifw, bub, fl, pst} !== 5'b11010) $display("FAIL lubr_flush got %b exp %b", {pcw, ifw, bub, fl, pst}, 5'b11010); else n_pass++;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (flush_cnt !== cnt_exp(flush_before + 16'd1)) $display("FAIL flush_cnt got %0d exp %0d", flush_cnt, cnt_exp(flush_before + 16'd1)); else n_pass++;
  endtask

  task automatic test_timeout();
    @(negedge clk_i) rst_i = 1'b1;
    #1;
    @(negedge clk_i) rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_in(5'd1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1);
      n_total++; if (to3 !== (i >= 3)) $display("FAIL timeout3[%0d] got %b exp %b", i, to3, (i >= 3)); else n_pass++;
    end
    n_total++; if (to !== 1'b0) $display("FAIL timeout255 got %b exp 0", to); else n_pass++;
    set_in(5'd1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
    set_in(5'd1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (to3 !== 1'b1 || pst3 !== 1'b0) $display("FAIL timeout_sticky got to=%b pst=%b exp 1/0", to3, pst3); else n_pass++;
  endtask

  task automatic test_reset_mid_miss();
    for (int i = 0; i < 3; i++) set_in(5'd1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b1);
    @(negedge clk_i) rst_i = 1'b1;
    #1;
    n_total++; if ({pcw, ifw, bub, fl, pst} !== 5'b11000) $display("FAIL rstmiss_ctrl got %b exp %b", {pcw, ifw, bub, fl, pst}, 5'b11000); else n_pass++;
    n_total++; if (to3 !== 1'b0 || to !== 1'b0) $display("FAIL rstmiss_timeout got %b/%b exp 0/0", to, to3); else n_pass++;
    n_total++; if ({miss_cnt, lu_cnt, flush_cnt} !== 48'd0) $display("FAIL rstmiss_cnt got %0d/%0d/%0d exp 0/0/0", miss_cnt, lu_cnt, flush_cnt); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0; st = 1'b0; ex_mr = 1'b0;
  endtask

  task automatic test_random();
    logic s;
    s = 1'b0;
    for (int n = 0; n < 400; n++) begin
      s = s ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3), s);
      n_total++; if ({pcw, ifw, bub, fl, pst} !== exp_ctrl()) $display("FAIL rnd_ctrl[%0d] got %b exp %b", n, {pcw, ifw, bub, fl, pst}, exp_ctrl()); else n_pass++;
      n_total++; if ({pcw3, ifw3, bub3, fl3, pst3} !== exp_ctrl()) $display("FAIL rnd_ctrl3[%0d] got %b exp %b", n, {pcw3, ifw3, bub3, fl3, pst3}, exp_ctrl()); else n_pass++;
      n_total++; if (to !== m_to || to3 !== m_to3) $display("FAIL rnd_timeout[%0d] got %b/%b exp %b/%b", n, to, to3, m_to, m_to3); else n_pass++;
      n_total++; if ({lu_cnt, miss_cnt, flush_cnt} !== {cnt_exp(m_lu), cnt_exp(m_miss), cnt_exp(m_flush)})
        $display("FAIL rnd_cnt[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", n, lu_cnt, miss_cnt, flush_cnt, cnt_exp(m_lu), cnt_exp(m_miss), cnt_exp(m_flush));
      else n_pass++;
      n_total++; if ({lu_cnt3, miss_cnt3, flush_cnt3} !== {cnt_exp(m_lu), cnt_exp(m_miss), cnt_exp(m_flush)})
        $display("FAIL rnd_cnt3[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", n, lu_cnt3, miss_cnt3, flush_cnt3, cnt_exp(m_lu), cnt_exp(m_miss), cnt_exp(m_flush));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_miss();
    test_lu_branch();
    test_timeout();
    test_reset_mid_miss();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
